pipe_stall_ctrl: RTL and testbench

Consumer end of the hazard-detection interface. Takes the `data_hazard` and `PC_hazard` stall requests plus `PC_update` and drives the pipeline-register write enables and flushes. It sequences data stalls (hold PC and IF/ID, inject bubbles into ID/EX) and control drains for call/ret (squash fetch until the new PC lands). It also provides a halt terminal state and a stall watchdog. Sits between the hazard unit and the PC/IFID/IDEX registers.

---
 rtl/pipe_stall_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: drives PC / IF-ID / ID-EX write enables and flushes for data stalls and call/ret drains.
// Optional build macro STALL_PERF_CNT_EN adds saturating stall/drain cycle counters.
module pipe_stall_ctrl #(
  parameter int STALL_MAX = 32,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_hazard,
  input  logic       PC_hazard,
  input  logic       PC_update,
  input  logic       hlt,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] stall_state,
  output logic       stall_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [15:0] perf_dstall,
  output logic [15:0] perf_cdrain
`endif
);

  // state  | meaning
  // RUN    | normal flow, requests serviced with zero latency
  // DSTALL | data hazard: hold PC and IF/ID, bubble into ID/EX
  // CDRAIN | call/ret drain: squash fetch until the new PC lands
  // HALT   | terminal, left only by reset
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DSTALL = 2'b01,
    CDRAIN = 2'b10,
    HALT   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STALL_MAX - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic             dh, ph;

  // An unknown request reads as "no request" rather than propagating X into the enables.
  assign dh = (data_hazard === 1'b1);
  assign ph = (PC_hazard === 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stall_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state)
      RUN: begin
        cnt_nxt = '0;
        if (hlt) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          state_nxt = HALT;
        end else if (ph) begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          state_nxt  = CDRAIN;
        end else if (dh) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          state_nxt  = DSTALL;
        end
      end
      DSTALL: begin
        if (dh) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        end else if (ph) begin
          state_nxt = CDRAIN;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
        if (hlt) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
          state_nxt  = HALT;
        end
      end
      CDRAIN: begin
        pc_we      = PC_update;
        ifid_flush = 1'b1;
        if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        if (PC_update) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
        if (hlt) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          ifid_flush = 1'b0;
          state_nxt  = HALT;
        end
      end
      default: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
      end
    endcase
    // Reset value of the enables is a safe "flush everything" pattern.
    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign err_nxt     = stall_err | (((state == DSTALL) || (state == CDRAIN)) && (cnt >= CNT_TC));
  assign stall_state = state;

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dstall <= '0;
      perf_cdrain <= '0;
    end else begin
      if (idex_flush && ((state == RUN) || (state == DSTALL)) && (perf_dstall != 16'hFFFF))
        perf_dstall <= perf_dstall + 16'd1;
      if ((state == CDRAIN) && (perf_cdrain != 16'hFFFF))
        perf_cdrain <= perf_cdrain + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random requests against a flag-based reference model.
// Builds with or without STALL_PERF_CNT_EN.
module tb_pipe_stall_ctrl;
  localparam int STALL_MAX = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       data_hazard = 1'b0, PC_hazard = 1'b0, PC_update = 1'b0, hlt = 1'b0;
  logic       pc_we, ifid_we, ifid_flush, idex_flush, stall_err;
  logic [1:0] stall_state;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] perf_dstall, perf_cdrain;
`endif

  int checks = 0;
  int failures = 0;

  pipe_stall_ctrl #(.STALL_MAX(STALL_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_hazard(data_hazard), .PC_hazard(PC_hazard), .PC_update(PC_update), .hlt(hlt),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_state(stall_state), .stall_err(stall_err)
`ifdef STALL_PERF_CNT_EN
    , .perf_dstall(perf_dstall), .perf_cdrain(perf_cdrain)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what the pipeline is doing, as plain flags and an unbounded cycle tally.
  bit m_halted, m_data_stall, m_draining, m_err;
  int m_len, m_perf_d, m_perf_c;

  function automatic void model_reset();
    m_halted = 0; m_data_stall = 0; m_draining = 0; m_err = 0;
    m_len = 0; m_perf_d = 0; m_perf_c = 0;
  endfunction

  // Expected {pc_we, ifid_we, ifid_flush, idex_flush, stall_state[1:0], stall_err} for this cycle.
  function automatic logic [6:0] model_out();
    logic [3:0] en;
    logic [1:0] st;
    bit dh = data_hazard, ph = PC_hazard, pu = PC_update, h = hlt;
    st = m_halted ? 2'd3 : m_draining ? 2'd2 : m_data_stall ? 2'd1 : 2'd0;
    if (m_halted || h)     en = 4'b0000;
    else if (m_draining)   en = {pu, 3'b110};
    else if (m_data_stall) en = dh ? 4'b0001 : 4'b1100;
    else if (ph)           en = 4'b0110;
    else if (dh)           en = 4'b0001;
    else                   en = 4'b1100;
    return {en, st, m_err};
  endfunction

  function automatic void model_step();
    logic [6:0] o = model_out();
    bit dh = data_hazard, ph = PC_hazard, pu = PC_update, h = hlt;
    if (!m_halted && !m_draining && o[3]) m_perf_d++;
    if (m_draining && !m_halted) m_perf_c++;
    if (!m_halted && (m_data_stall || m_draining) && m_len >= STALL_MAX - 1) m_err = 1;
    if (m_halted) begin
    end else if (h) begin
      m_halted = 1; m_data_stall = 0; m_draining = 0;
    end else if (m_draining) begin
      m_len++;
      if (pu) begin m_draining = 0; m_len = 0; end
    end else if (m_data_stall) begin
      if (dh) m_len++;
      else begin
        m_data_stall = 0;
        if (ph) m_draining = 1; else m_len = 0;
      end
    end else if (ph) begin
      m_draining = 1; m_len = 0;
    end else if (dh) begin
      m_data_stall = 1; m_len = 0;
    end
  endfunction

  task automatic drive(input bit dh, input bit ph, input bit pu, input bit h);
    @(negedge clk);
    data_hazard = dh; PC_hazard = ph; PC_update = pu; hlt = h;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data_hazard = 0; PC_hazard = 0; PC_update = 0; hlt = 0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== 7'b0011_00_0) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, 7'b0011_00_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL idle_run cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
  endtask

  task automatic test_data_stall();
    logic [6:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 0, 0, 0);
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL data_stall cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
  endtask

  task automatic test_ctrl_drain();
    logic [6:0] exp;
    for (int i = 0; i < 7; i++) begin
      drive(0, i == 0, i == 4, 0);
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL ctrl_drain cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
  endtask

  // Enter DSTALL, raise PC_hazard alongside, drop data_hazard, then drain and update.
  task automatic test_data_then_ctrl();
    logic [6:0] exp;
    bit dh_v[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    bit ph_v[8] = '{0, 1, 1, 0, 0, 0, 0, 0};
    bit pu_v[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      drive(dh_v[i], ph_v[i], pu_v[i], 0);
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL data_then_ctrl cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
  endtask

  task automatic test_run_priority();
    logic [6:0] exp;
    bit dh_v[6] = '{1, 0, 0, 1, 0, 0};
    bit ph_v[6] = '{1, 0, 1, 1, 0, 0};
    bit pu_v[6] = '{0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(dh_v[i], ph_v[i], pu_v[i], 0);
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL run_priority cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
  endtask

  task automatic test_watchdog();
    logic [6:0] exp;
    for (int i = 0; i < 45; i++) begin
      drive(i < 40, 0, 0, 0);
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL watchdog cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
    checks++;
    if (stall_err !== 1'b1) begin
      failures++;
      $display("FAIL watchdog_sticky got=%b exp=1", stall_err);
    end
    do_reset();
    #1;
    checks++;
    if (stall_err !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_clear got=%b exp=0", stall_err);
    end
  endtask

  task automatic test_halt();
    logic [6:0] exp;
    for (int i = 0; i < 10; i++) begin
      if (i < 4)       drive(0, i == 0, 0, 0);
      else if (i == 4) drive(0, 0, 1, 1);
      else             drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL halt cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== 7'b0011_00_0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, 7'b0011_00_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    data_hazard = 0; PC_hazard = 0; PC_update = 0; hlt = 0;
    model_reset();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30, 0);
      exp = model_out();
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err} !== exp) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, {pc_we, ifid_we, ifid_flush, idex_flush, stall_state, stall_err}, exp);
      end
      advance();
    end
`ifdef STALL_PERF_CNT_EN
    #1;
    checks++;
    if (perf_dstall !== 16'(m_perf_d)) begin
      failures++;
      $display("FAIL perf_dstall got=%0d exp=%0d", perf_dstall, m_perf_d);
    end
    checks++;
    if (perf_cdrain !== 16'(m_perf_c)) begin
      failures++;
      $display("FAIL perf_cdrain got=%0d exp=%0d", perf_cdrain, m_perf_c);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_data_stall();
    test_ctrl_drain();
    test_data_then_ctrl();
    test_run_priority();
    test_watchdog();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
